ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. It sends command bytes to the keyboard, for example 0xED (set LEDs), 0xFF (reset) and 0xF3 (typematic rate). It is the opposite direction of the existing kb_driver receiver and shares the same open-collector PS2_CLK/PS2_DAT lines. The CPU-facing memory map issues bytes through a valid/ready handshake, and the block reports completion, device ACK and timeout status.

---
 rtl/ps2_host_tx.sv | 242 ++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (host drives CLK/DAT
// through open-collector enables, device clocks the frame back).
// Optional build macro PS2_TX_RETRY_EN: retry once from INHIBIT after a
// missing ACK or a packet timeout before reporting the result.
module ps2_host_tx #(
   parameter int unsigned CLK_FREQ          = 50000000,
   parameter int unsigned INHIBIT_US        = 120,
   parameter int unsigned START_TIMEOUT_US  = 15000,
   parameter int unsigned PACKET_TIMEOUT_US = 2000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       tx_done,
   output logic [1:0] tx_err
);

   localparam int unsigned CYC_US      = CLK_FREQ / 1000000;
   localparam logic [31:0] INHIBIT_CYC = 32'(INHIBIT_US * CYC_US);
   localparam logic [31:0] START_CYC   = 32'(START_TIMEOUT_US * CYC_US);
   localparam logic [31:0] PACKET_CYC  = 32'(PACKET_TIMEOUT_US * CYC_US);

   localparam logic [1:0] ERR_OK       = 2'b00;
   localparam logic [1:0] ERR_NOACK    = 2'b01;
   localparam logic [1:0] ERR_START_TO = 2'b10;
   localparam logic [1:0] ERR_PKT_TO   = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_WAIT_FIRST,
      S_SEND,
      S_ACK,
      S_WAIT_IDLE,
      S_FINISH
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  clk_sync_q, dat_sync_q;
   logic        clk_prev_q, fall_q;
   logic [7:0]  shreg_q, shreg_d;
   logic        parity_q, parity_d;
   logic [3:0]  bitcnt_q, bitcnt_d;
   logic [31:0] cnt_q;
   logic        cnt_clr;
   logic        clk_oe_q, clk_oe_d;
   logic        dat_oe_q, dat_oe_d;
   logic [1:0]  err_q, err_d;
   logic        go_finish;
   logic [1:0]  finish_err;
   logic        pkt_expired;
`ifdef PS2_TX_RETRY_EN
   logic        retry_q, retry_d;
`endif

   // Synchronize the pads and register a one-cycle pulse per falling CLK edge.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
         clk_prev_q <= 1'b1;
         fall_q     <= 1'b0;
      end else begin
         clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
         dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
         clk_prev_q <= clk_sync_q[1];
         fall_q     <= clk_prev_q & ~clk_sync_q[1];
      end
   end

   // Phase timer: restarted for inhibit, start wait and packet; the packet
   // phase keeps running through SEND, ACK and WAIT_IDLE.
   always_ff @(posedge clk) begin
      if (!rst_n || cnt_clr || state_q == S_IDLE) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 32'd1;
      end
   end

   assign pkt_expired = (cnt_q == PACKET_CYC - 32'd1);

   // FSM state and registered line enables.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         shreg_q  <= '0;
         parity_q <= 1'b0;
         bitcnt_q <= '0;
         clk_oe_q <= 1'b0;
         dat_oe_q <= 1'b0;
         err_q    <= ERR_OK;
`ifdef PS2_TX_RETRY_EN
         retry_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         parity_q <= parity_d;
         bitcnt_q <= bitcnt_d;
         clk_oe_q <= clk_oe_d;
         dat_oe_q <= dat_oe_d;
         err_q    <= err_d;
`ifdef PS2_TX_RETRY_EN
         retry_q  <= retry_d;
`endif
      end
   end

   // Next-state logic: frame sequencing, timeouts and line control.
   // NOTE: every variable gets a default first so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      parity_d   = parity_q;
      bitcnt_d   = bitcnt_q;
      clk_oe_d   = clk_oe_q;
      dat_oe_d   = dat_oe_q;
      err_d      = err_q;
      cnt_clr    = 1'b0;
      go_finish  = 1'b0;
      finish_err = err_q;
`ifdef PS2_TX_RETRY_EN
      retry_d    = retry_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (tx_valid) begin
               shreg_d  = tx_data;
               parity_d = ~^tx_data;
               err_d    = ERR_OK;
               clk_oe_d = 1'b1;
               dat_oe_d = 1'b0;
               cnt_clr  = 1'b1;
               state_d  = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
               retry_d  = 1'b0;
`endif
            end
         end
         S_INHIBIT: begin
            // Falls caused by our own inhibit (or device glitches) are ignored.
            if (cnt_q == INHIBIT_CYC - 32'd1) begin
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b1;
               cnt_clr  = 1'b1;
               state_d  = S_WAIT_FIRST;
            end
         end
         S_WAIT_FIRST: begin
            if (fall_q) begin
               dat_oe_d = ~shreg_q[0];
               bitcnt_d = 4'd1;
               cnt_clr  = 1'b1;
               state_d  = S_SEND;
            end else if (cnt_q == START_CYC - 32'd1) begin
               go_finish  = 1'b1;
               finish_err = ERR_START_TO;
            end
         end
         S_SEND: begin
            if (pkt_expired) begin
               go_finish  = 1'b1;
               finish_err = ERR_PKT_TO;
            end else if (fall_q) begin
               if (bitcnt_q == 4'd9) begin
                  dat_oe_d = 1'b0;
                  state_d  = S_ACK;
               end else if (bitcnt_q == 4'd8) begin
                  dat_oe_d = ~parity_q;
               end else begin
                  dat_oe_d = ~shreg_q[bitcnt_q[2:0]];
               end
               bitcnt_d = bitcnt_q + 4'd1;
            end
         end
         S_ACK: begin
            if (pkt_expired) begin
               go_finish  = 1'b1;
               finish_err = ERR_PKT_TO;
            end else if (fall_q) begin
               if (dat_sync_q[1]) begin
                  err_d = ERR_NOACK;
               end
               state_d = S_WAIT_IDLE;
            end
         end
         S_WAIT_IDLE: begin
            if (pkt_expired) begin
               go_finish  = 1'b1;
               finish_err = ERR_PKT_TO;
            end else if (clk_sync_q[1] && dat_sync_q[1]) begin
               go_finish  = 1'b1;
               finish_err = err_q;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (go_finish) begin
         state_d  = S_FINISH;
         err_d    = finish_err;
         clk_oe_d = 1'b0;
         dat_oe_d = 1'b0;
      end

`ifdef PS2_TX_RETRY_EN
      // A device that never clocked is not retried; a bad frame is, once.
      if (go_finish && !retry_q &&
          (finish_err == ERR_NOACK || finish_err == ERR_PKT_TO)) begin
         state_d  = S_INHIBIT;
         err_d    = ERR_OK;
         clk_oe_d = 1'b1;
         dat_oe_d = 1'b0;
         cnt_clr  = 1'b1;
         retry_d  = 1'b1;
      end
`endif
   end

   assign tx_ready   = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign tx_done    = (state_q == S_FINISH);
   assign tx_err     = err_q;
   assign ps2_clk_oe = clk_oe_q;
   assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives ps2_host_tx against a behavioural PS/2 device that
// clocks frames on a 40-cycle period and checks the bits it samples against
// a byte-level frame model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

   localparam int unsigned CLK_FREQ          = 1000000;
   localparam int unsigned INHIBIT_US        = 120;
   localparam int unsigned START_TIMEOUT_US  = 15000;
   localparam int unsigned PACKET_TIMEOUT_US = 2000;
   localparam int CYC_US      = CLK_FREQ / 1000000;
   localparam int INHIBIT_CYC = INHIBIT_US * CYC_US;
   localparam int START_CYC   = START_TIMEOUT_US * CYC_US;
   localparam int HALF        = 20;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
   logic       busy, tx_done;
   logic [1:0] tx_err;
   logic       dev_clk_low = 1'b0;
   logic       dev_dat_low = 1'b0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = -1;
   int ready_cyc = -1;
   logic [1:0] done_err = 2'b00;

   // Open-collector wired-AND of host and device on each line.
   assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

   ps2_host_tx #(
      .CLK_FREQ(CLK_FREQ),
      .INHIBIT_US(INHIBIT_US),
      .START_TIMEOUT_US(START_TIMEOUT_US),
      .PACKET_TIMEOUT_US(PACKET_TIMEOUT_US)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
      .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe),
      .busy(busy), .tx_done(tx_done), .tx_err(tx_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Record every done pulse and every cycle where a byte would be accepted.
   always @(negedge clk) begin
      if (tx_done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
         done_err = tx_err;
      end
      if (tx_ready === 1'b1 && tx_valid === 1'b1) ready_cyc = cyc;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

   // Reference frame as the device should see it: data LSB first, odd parity, stop.
   function automatic logic [9:0] frame_bits(input logic [7:0] b);
      logic [9:0] f;
      int v;
      int ones;
      v = int'(b);
      ones = 0;
      for (int i = 0; i < 8; i++) begin
         f[i] = ((v >> i) % 2) == 1;
         ones += (v >> i) % 2;
      end
      f[8] = (ones % 2) == 0;
      f[9] = 1'b1;
      return f;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      tx_data  = b;
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
   endtask

   // ack_mode: 0 = no 11th clock, 1 = ACK clock with DAT low, 2 = 11th clock without ACK.
   task automatic device_run(input int n_pulses, input int ack_mode, output logic [9:0] bits);
      int waited;
      waited = 0;
      bits = '0;
      while (!(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) && waited < 1000) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (waited >= 1000) begin
         errors++;
         $display("FAIL dev_request got clk_oe=%b dat_oe=%b exp clk_oe=0 dat_oe=1", ps2_clk_oe, ps2_dat_oe);
         return;
      end
      repeat (10) @(negedge clk);
      for (int k = 0; k < n_pulses; k++) begin
         dev_clk_low = 1'b1;
         repeat (HALF) @(negedge clk);
         bits[k] = ps2_dat_in;
         dev_clk_low = 1'b0;
         repeat (HALF) @(negedge clk);
      end
      if (ack_mode != 0) begin
         dev_dat_low = (ack_mode == 1);
         repeat (5) @(negedge clk);
         dev_clk_low = 1'b1;
         repeat (HALF) @(negedge clk);
         dev_clk_low = 1'b0;
         repeat (5) @(negedge clk);
         dev_dat_low = 1'b0;
      end
   endtask

   task automatic wait_done(input int prev, input int bound, output int pulses);
      int n;
      n = 0;
      while (done_cnt == prev && n < bound) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      pulses = done_cnt - prev;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL rst_clk_oe got %b exp 0", ps2_clk_oe); end
      checks++; if (ps2_dat_oe !== 1'b0) begin errors++; $display("FAIL rst_dat_oe got %b exp 0", ps2_dat_oe); end
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_tx_ready got %b exp 1", tx_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
      checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL rst_tx_done got %b exp 0", tx_done); end
      checks++; if (tx_err !== 2'b00) begin errors++; $display("FAIL rst_tx_err got %b exp 00", tx_err); end
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_inhibit_ack();
      int n;
      int prev;
      int pulses;
      logic [9:0] bits;
      prev = done_cnt;
      send_byte(8'hED);
      @(negedge clk);
      checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL inh_tx_ready got %b exp 0", tx_ready); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL inh_busy got %b exp 1", busy); end
      n = 0;
      while (ps2_clk_oe === 1'b1 && n < 1000) begin
         checks++;
         if (ps2_dat_oe !== 1'b0) begin errors++; $display("FAIL inh_dat_oe_early got %b exp 0", ps2_dat_oe); end
         n++;
         @(negedge clk);
      end
      checks++; if (n != INHIBIT_CYC) begin errors++; $display("FAIL inh_len got %0d exp %0d", n, INHIBIT_CYC); end
      checks++; if (ps2_dat_oe !== 1'b1) begin errors++; $display("FAIL inh_start_bit got %b exp 1", ps2_dat_oe); end
      device_run(10, 1, bits);
      wait_done(prev, 3000, pulses);
      checks++; if (bits !== frame_bits(8'hED)) begin errors++; $display("FAIL ed_bits got %b exp %b", bits, frame_bits(8'hED)); end
      checks++; if (pulses != 1) begin errors++; $display("FAIL ed_done got %0d exp 1", pulses); end
      checks++; if (done_err !== 2'b00) begin errors++; $display("FAIL ed_err got %b exp 00", done_err); end
      checks++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin errors++; $display("FAIL ed_lines got %b exp 00", {ps2_clk_oe, ps2_dat_oe}); end
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL ed_ready got %b exp 1", tx_ready); end
   endtask

   task automatic test_parity_noack();
      int prev;
      int pulses;
      logic [9:0] bits;
      prev = done_cnt;
      send_byte(8'h01);
      device_run(10, 2, bits);
      wait_done(prev, 3000, pulses);
      checks++; if (bits !== frame_bits(8'h01)) begin errors++; $display("FAIL p0_bits got %b exp %b", bits, frame_bits(8'h01)); end
      checks++; if (pulses != 1) begin errors++; $display("FAIL p0_done got %0d exp 1", pulses); end
      checks++; if (tx_err !== 2'b01) begin errors++; $display("FAIL p0_err got %b exp 01", tx_err); end
   endtask

   task automatic test_start_timeout();
      int n;
      int prev;
      prev = done_cnt;
      send_byte(8'(($urandom % 256)));
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ps2_clk_oe !== 1'b0 && n < 1000);
      n = 0;
      while (tx_done !== 1'b1 && n < START_CYC + 1000) begin
         @(negedge clk);
         n++;
      end
      checks++; if (n != START_CYC) begin errors++; $display("FAIL sto_latency got %0d exp %0d", n, START_CYC); end
      checks++; if (tx_err !== 2'b10) begin errors++; $display("FAIL sto_err got %b exp 10", tx_err); end
      checks++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin errors++; $display("FAIL sto_lines got %b exp 00", {ps2_clk_oe, ps2_dat_oe}); end
      repeat (3) @(negedge clk);
      checks++; if (done_cnt - prev != 1) begin errors++; $display("FAIL sto_done got %0d exp 1", done_cnt - prev); end
   endtask

   task automatic test_packet_timeout();
      int prev;
      int pulses;
      logic [7:0] b;
      logic [9:0] bits;
      logic [9:0] exp_bits;
      b = 8'($urandom % 256);
      exp_bits = frame_bits(b);
      prev = done_cnt;
      send_byte(b);
      device_run(4, 0, bits);
      wait_done(prev, 3000, pulses);
      checks++; if (bits[3:0] !== exp_bits[3:0]) begin errors++; $display("FAIL pto_bits got %b exp %b", bits[3:0], exp_bits[3:0]); end
      checks++; if (pulses != 1) begin errors++; $display("FAIL pto_done got %0d exp 1", pulses); end
      checks++; if (done_err !== 2'b11) begin errors++; $display("FAIL pto_err got %b exp 11", done_err); end
      checks++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin errors++; $display("FAIL pto_lines got %b exp 00", {ps2_clk_oe, ps2_dat_oe}); end
   endtask

   task automatic test_reset_mid_send();
      int prev;
      int pulses;
      logic [9:0] bits;
      prev = done_cnt;
      send_byte(8'(($urandom % 256) | 8'h01));
      device_run(5, 0, bits);
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin errors++; $display("FAIL mid_rst_lines got %b exp 00", {ps2_clk_oe, ps2_dat_oe}); end
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b exp 1", tx_ready); end
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      checks++; if (done_cnt != prev) begin errors++; $display("FAIL mid_rst_no_done got %0d exp 0", done_cnt - prev); end
      prev = done_cnt;
      send_byte(8'hFF);
      device_run(10, 1, bits);
      wait_done(prev, 3000, pulses);
      checks++; if (bits !== frame_bits(8'hFF)) begin errors++; $display("FAIL ff_bits got %b exp %b", bits, frame_bits(8'hFF)); end
      checks++; if (pulses != 1) begin errors++; $display("FAIL ff_done got %0d exp 1", pulses); end
      checks++; if (done_err !== 2'b00) begin errors++; $display("FAIL ff_err got %b exp 00", done_err); end
   endtask

   task automatic test_random();
      int prev;
      int pulses;
      int mode;
      logic [7:0] b;
      logic [9:0] bits;
      logic [1:0] exp_err;
      for (int i = 0; i < 6; i++) begin
         b = 8'($urandom % 256);
         mode = ($urandom % 2 == 0) ? 1 : 2;
         exp_err = (mode == 1) ? 2'b00 : 2'b01;
         prev = done_cnt;
         send_byte(b);
         device_run(10, mode, bits);
         wait_done(prev, 3000, pulses);
         checks++; if (bits !== frame_bits(b)) begin errors++; $display("FAIL rnd%0d_bits byte %h got %b exp %b", i, b, bits, frame_bits(b)); end
         checks++; if (pulses != 1) begin errors++; $display("FAIL rnd%0d_done got %0d exp 1", i, pulses); end
         checks++; if (tx_err !== exp_err) begin errors++; $display("FAIL rnd%0d_err got %b exp %b", i, tx_err, exp_err); end
      end
   endtask

   task automatic test_back_to_back();
      int prev;
      int pulses;
      int n;
      logic [7:0] a;
      logic [7:0] b;
      logic [9:0] bits;
      a = 8'($urandom % 256);
      b = ~a;
      prev = done_cnt;
      @(negedge clk);
      tx_data  = a;
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      tx_data = b;
      device_run(10, 1, bits);
      checks++; if (bits !== frame_bits(a)) begin errors++; $display("FAIL b2b_first_bits got %b exp %b", bits, frame_bits(a)); end
      n = 0;
      while (done_cnt == prev && n < 3000) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy !== 1'b1 && n < 100);
      tx_valid = 1'b0;
      checks++; if (done_err !== 2'b00) begin errors++; $display("FAIL b2b_first_err got %b exp 00", done_err); end
      checks++; if (ready_cyc != done_cyc + 1) begin errors++; $display("FAIL b2b_accept_cycle got %0d exp %0d", ready_cyc, done_cyc + 1); end
      prev = done_cnt;
      device_run(10, 1, bits);
      wait_done(prev, 3000, pulses);
      checks++; if (bits !== frame_bits(b)) begin errors++; $display("FAIL b2b_second_bits got %b exp %b", bits, frame_bits(b)); end
      checks++; if (pulses != 1) begin errors++; $display("FAIL b2b_second_done got %0d exp 1", pulses); end
      checks++; if (done_err !== 2'b00) begin errors++; $display("FAIL b2b_second_err got %b exp 00", done_err); end
   endtask

   initial begin
      test_reset();
      test_inhibit_ack();
      test_parity_noack();
      test_start_timeout();
      test_packet_timeout();
      test_reset_mid_send();
      test_random();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
